dense2_bias_apply_argmax: RTL and testbench

- Consumer of the dense-layer-2 (128->9) bias ROM.
- Accepts the 9 raw MAC accumulator results of the final dense layer, one per class, in order 0..8.
- For each result it fetches that class's int8 bias by address, adds the scaled bias, rounds, requantises and saturates to int8, then streams the logit out.
- After the 9th class it reports the argmax. This gives the wafer-defect class decision to the SoC-side result register.

---
 rtl/dense2_bias_apply_argmax.sv | 120 ++++++++++++
 tb/tb_dense2_bias_apply_argmax.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense2_bias_apply_argmax.sv
`default_nettype none
// ============================================================================
// Module : dense2_bias_apply_argmax
// Adds each class bias to its dense-2 accumulator, requantises to int8,
// streams the logits and reports the argmax class once per frame.
// Rev    : 1.0
// ============================================================================
module dense2_bias_apply_argmax #(
   parameter int ACC_W       = 24,
   parameter int BIAS_SHIFT  = 8,
   parameter int OUT_SHIFT   = 8,
   parameter int NUM_CLASSES = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_acc_valid,
   input  logic signed [ACC_W-1:0] i_acc_data,
   output logic                    o_acc_ready,
   output logic [3:0]              o_bias_addr,
   input  logic signed [7:0]       i_bias_data,
   output logic                    o_out_valid,
   output logic signed [7:0]       o_out_data,
   output logic [3:0]              o_out_idx,
   output logic                    o_out_last,
   input  logic                    i_out_ready,
   output logic                    o_class_valid,
   output logic [3:0]              o_class_id,
   output logic signed [7:0]       o_class_score
);
   localparam int SUM_W = ACC_W + 1;
   localparam int RND_W = SUM_W + 1;
   localparam logic [3:0]              c_LAST_IDX = 4'(NUM_CLASSES - 1);
   localparam logic signed [RND_W-1:0] c_RND      = RND_W'(2 ** (OUT_SHIFT - 1));
   localparam logic signed [RND_W-1:0] c_Q_MAX    = RND_W'(127);
   localparam logic signed [RND_W-1:0] c_Q_MIN    = RND_W'(-128);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_DONE = 1'b1
   } state_t;

   state_t            r_state;
   logic [3:0]        r_idx;
   logic signed [7:0] r_best;
   logic [3:0]        r_best_idx;

   logic                    w_accept;
   logic signed [SUM_W-1:0] w_bias_al;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [RND_W-1:0] w_r;
   logic signed [7:0]       w_q;
   logic                    w_take;
   logic signed [7:0]       w_best_nxt;
   logic [3:0]              w_best_idx_nxt;

   assign o_acc_ready = (r_state == S_RUN) && (!o_out_valid || i_out_ready);
   assign o_bias_addr = r_idx;
   assign w_accept    = i_acc_valid && o_acc_ready;

   assign w_bias_al = $signed({{(SUM_W-8){i_bias_data[7]}}, i_bias_data}) <<< BIAS_SHIFT;
   assign w_sum     = $signed({i_acc_data[ACC_W-1], i_acc_data}) + w_bias_al;
   // Extra headroom bit so the rounding offset can never wrap the sum.
   assign w_r       = ($signed({w_sum[SUM_W-1], w_sum}) + c_RND) >>> OUT_SHIFT;

   always_comb begin
      if (w_r > c_Q_MAX) begin
         w_q = 8'sh7F;
      end else if (w_r < c_Q_MIN) begin
         w_q = 8'sh80;
      end else begin
         w_q = w_r[7:0];
      end
   end

   // Strict compare keeps the lower index on ties.
   assign w_take         = (r_idx == 4'd0) || (w_q > r_best);
   assign w_best_nxt     = w_take ? w_q   : r_best;
   assign w_best_idx_nxt = w_take ? r_idx : r_best_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_RUN;
         r_idx         <= 4'd0;
         r_best        <= 8'sd0;
         r_best_idx    <= 4'd0;
         o_out_valid   <= 1'b0;
         o_out_data    <= 8'sd0;
         o_out_idx     <= 4'd0;
         o_out_last    <= 1'b0;
         o_class_valid <= 1'b0;
         o_class_id    <= 4'd0;
         o_class_score <= 8'sd0;
      end else begin
         o_class_valid <= 1'b0;
         if (r_state == S_DONE) begin
            r_state <= S_RUN;
         end
         if (w_accept) begin
            o_out_valid <= 1'b1;
            o_out_data  <= w_q;
            o_out_idx   <= r_idx;
            o_out_last  <= (r_idx == c_LAST_IDX);
            r_best      <= w_best_nxt;
            r_best_idx  <= w_best_idx_nxt;
            if (r_idx == c_LAST_IDX) begin
               r_idx         <= 4'd0;
               r_state       <= S_DONE;
               o_class_valid <= 1'b1;
               o_class_id    <= w_best_idx_nxt;
               o_class_score <= w_best_nxt;
            end else begin
               r_idx <= r_idx + 4'd1;
            end
         end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dense2_bias_apply_argmax.sv
`default_nettype none
// ============================================================================
// Module : tb_dense2_bias_apply_argmax
// Directed frames against a scoreboard of expected logits and argmax results.
// Rev    : 1.0
// ============================================================================
module tb_dense2_bias_apply_argmax;
   localparam int ACC_W = 24;
   localparam int NCLS  = 9;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    i_acc_valid;
   logic signed [ACC_W-1:0] i_acc_data;
   logic                    o_acc_ready;
   logic [3:0]              o_bias_addr;
   logic signed [7:0]       i_bias_data;
   logic                    o_out_valid;
   logic signed [7:0]       o_out_data;
   logic [3:0]              o_out_idx;
   logic                    o_out_last;
   logic                    i_out_ready;
   logic                    o_class_valid;
   logic [3:0]              o_class_id;
   logic signed [7:0]       o_class_score;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic signed [7:0] data;
      logic [3:0]        idx;
      logic              last;
   } out_exp_t;

   typedef struct packed {
      logic [3:0]        id;
      logic signed [7:0] score;
   } cls_exp_t;

   out_exp_t          q_out[$];
   cls_exp_t          q_cls[$];
   logic signed [7:0] rom [NCLS];
   int                m_idx;
   logic signed [7:0] m_best;
   logic [3:0]        m_best_idx;

   dense2_bias_apply_argmax #(
      .ACC_W      (ACC_W),
      .BIAS_SHIFT (8),
      .OUT_SHIFT  (8),
      .NUM_CLASSES(NCLS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_acc_valid  (i_acc_valid),
      .i_acc_data   (i_acc_data),
      .o_acc_ready  (o_acc_ready),
      .o_bias_addr  (o_bias_addr),
      .i_bias_data  (i_bias_data),
      .o_out_valid  (o_out_valid),
      .o_out_data   (o_out_data),
      .o_out_idx    (o_out_idx),
      .o_out_last   (o_out_last),
      .i_out_ready  (i_out_ready),
      .o_class_valid(o_class_valid),
      .o_class_id   (o_class_id),
      .o_class_score(o_class_score)
   );

   always #5 clk = ~clk;

   always_comb begin
      i_bias_data = 8'sh55;
      if (int'(o_bias_addr) < NCLS) i_bias_data = rom[int'(o_bias_addr)];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [7:0] model(input int cls, input int acc);
      longint s;
      longint r;
      s = longint'(acc) + longint'(rom[cls]) * 256;
      r = (s + 128) >>> 8;
      if (r > 127) return 8'sh7F;
      if (r < -128) return 8'sh80;
      return 8'(r);
   endfunction

   // Drives one accumulator word, waits for acceptance and records expectations.
   task automatic send(input int d, input int exp_wait);
      int n;
      logic signed [7:0] q;
      n = 0;
      i_acc_valid = 1'b1;
      i_acc_data  = ACC_W'(d);
      #1;
      while (!o_acc_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!o_acc_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         i_acc_valid = 1'b0;
         return;
      end
      if (exp_wait >= 0) check("accept_wait", n, exp_wait);
      check("bias_addr", o_bias_addr, m_idx);
      q = model(m_idx, d);
      q_out.push_back('{data: q, idx: 4'(m_idx), last: (m_idx == NCLS - 1)});
      if (m_idx == 0 || q > m_best) begin
         m_best     = q;
         m_best_idx = 4'(m_idx);
      end
      if (m_idx == NCLS - 1) begin
         q_cls.push_back('{id: m_best_idx, score: m_best});
         m_idx = 0;
      end else begin
         m_idx++;
      end
      @(negedge clk);
   endtask

   task automatic done_checks();
      #1;
      check("done_class_valid", o_class_valid, 1);
      check("done_acc_ready", o_acc_ready, 0);
      check("done_bias_addr", o_bias_addr, 0);
   endtask

   initial begin
      out_exp_t eo;
      cls_exp_t ec;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && o_out_valid && i_out_ready) begin
            if (q_out.size() == 0) begin
               check("out_unexpected", 32'd1, 32'd0);
            end else begin
               eo = q_out.pop_front();
               check("out_data", o_out_data, eo.data);
               check("out_idx", o_out_idx, eo.idx);
               check("out_last", o_out_last, eo.last);
            end
         end
         if (!rst && o_class_valid) begin
            if (q_cls.size() == 0) begin
               check("class_unexpected", 32'd1, 32'd0);
            end else begin
               ec = q_cls.pop_front();
               check("class_id", o_class_id, ec.id);
               check("class_score", o_class_score, ec.score);
            end
         end
      end
   end

   initial begin
      rom = '{8'sd34, -8'sd108, 8'sd75, 8'sd127, 8'sd8, 8'sd0, 8'sd127, -8'sd45, -8'sd75};
      rst         = 1'b1;
      i_acc_valid = 1'b0;
      i_acc_data  = '0;
      i_out_ready = 1'b1;
      m_idx       = 0;
      m_best      = 8'sd0;
      m_best_idx  = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_out_data", o_out_data, 0);
      check("rst_out_idx", o_out_idx, 0);
      check("rst_out_last", o_out_last, 0);
      check("rst_class_valid", o_class_valid, 0);
      check("rst_class_id", o_class_id, 0);
      check("rst_class_score", o_class_score, 0);
      check("rst_bias_addr", o_bias_addr, 0);
      rst = 1'b0;

      // Zero accumulators: logits equal the biases, tie 3/6 resolves to 3.
      for (int c = 0; c < NCLS; c++) send(0, 0);
      done_checks();

      // Saturation both ways and round-up at class 5; acc_valid stays high over DONE.
      for (int c = 0; c < NCLS; c++)
         send((c == 1) ? -100000 : (c == 3) ? 40000 : (c == 5) ? 128 : 0, (c == 0) ? 1 : 0);
      done_checks();

      // Backpressure on the first output of the frame.
      send(0, 1);
      i_out_ready = 1'b0;
      i_acc_data  = '0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_acc_ready", o_acc_ready, 0);
         check("bp_out_valid", o_out_valid, 1);
         check("bp_out_data", o_out_data, 34);
         check("bp_out_idx", o_out_idx, 0);
         check("bp_class_id_hold", o_class_id, 3);
         @(negedge clk);
      end
      i_out_ready = 1'b1;
      for (int c = 1; c < NCLS; c++) send((c == 5) ? -129 : 0, 0);
      done_checks();

      for (int c = 0; c < NCLS; c++) send((c == 5) ? 127 : 0, (c == 0) ? 1 : 0);
      done_checks();

      for (int c = 0; c < NCLS; c++)
         send(int'($urandom_range(0, 2097151)) - 1048576, (c == 0) ? 1 : 0);
      done_checks();

      // Partial frame of large logits, then reset mid-frame.
      send(40000, 1);
      for (int c = 1; c < 4; c++) send(40000, 0);
      i_acc_valid = 1'b0;
      rst = 1'b1;
      q_out.delete();
      m_idx = 0;
      @(negedge clk);
      check("mid_rst_out_valid", o_out_valid, 0);
      check("mid_rst_class_id", o_class_id, 0);
      check("mid_rst_class_score", o_class_score, 0);
      check("mid_rst_bias_addr", o_bias_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < NCLS; c++) send((c == 0 || c == NCLS - 1) ? 0 : -60000, 0);
      done_checks();

      i_acc_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("final_class_id", o_class_id, 0);
      check("final_class_score", o_class_score, 34);
      check("out_queue_empty", q_out.size(), 0);
      check("class_queue_empty", q_cls.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
